// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command assembler.
// Used by the top-level FSM and the inter-byte timer.
package uart_cmd_pkg;

    typedef enum logic {
        WAIT_HI = 1'b0,
        WAIT_LO = 1'b1
    } asm_state_t;

    localparam int DEFAULT_TIMEOUT_CYCLES = 100_000;
    localparam int CMD_W                  = 16;
    localparam int BYTE_W                 = 8;

    // A single-cycle timeout would give a zero-width counter, so clamp to one bit.
    function automatic int timer_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/inter_byte_timer.sv
// Saturating up-counter measuring the gap between the high and low byte.
// It holds at its terminal count so a stalled link can never wrap it back to zero.
module inter_byte_timer
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int             W        = timer_width(TIMEOUT_CYCLES);
    localparam logic [W-1:0]   TERMINAL = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != TERMINAL)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == TERMINAL);

endmodule

// File: rtl/uart_cmd_assembler.sv
// Pairs received UART bytes, high byte first, into 16-bit commands.
// An inter-byte timeout drops a lone high byte so framing recovers after a lost byte.
module uart_cmd_assembler
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_rdy,
    output logic              clr_rx_rdy,
    output logic [CMD_W-1:0]  cmd,
    output logic              cmd_rdy,
    input  logic              clr_cmd_rdy,
    output logic              overrun,
    output logic              timeout
);

    asm_state_t          state_q, state_d;
    logic [BYTE_W-1:0]   hi_q, hi_d;
    logic [CMD_W-1:0]    cmd_q, cmd_d;
    logic                cmd_rdy_q, cmd_rdy_d;
    logic                overrun_q, overrun_d;
    logic                timer_clr;
    logic                timer_expired;
    logic                complete;

    inter_byte_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (timer_clr),
        .en     (state_q == WAIT_LO),
        .expired(timer_expired)
    );

    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        clr_rx_rdy = 1'b0;
        timeout    = 1'b0;
        timer_clr  = 1'b0;
        complete   = 1'b0;
        case (state_q)
            WAIT_HI: begin
                if (rx_rdy) begin
                    hi_d       = rx_data;
                    clr_rx_rdy = 1'b1;
                    timer_clr  = 1'b1;
                    state_d    = WAIT_LO;
                end
            end
            WAIT_LO: begin
                // A byte arriving in the expiry cycle still completes the command.
                if (rx_rdy) begin
                    clr_rx_rdy = 1'b1;
                    complete   = 1'b1;
                    state_d    = WAIT_HI;
                end else if (timer_expired) begin
                    timeout    = 1'b1;
                    hi_d       = '0;
                    state_d    = WAIT_HI;
                end
            end
            default: state_d = WAIT_HI;
        endcase
    end

    // Completion sets cmd_rdy even when acknowledged in the same cycle.
    always_comb begin
        cmd_d     = complete ? {hi_q, rx_data} : cmd_q;
        cmd_rdy_d = complete | (cmd_rdy_q & ~clr_cmd_rdy);
        overrun_d = ~clr_cmd_rdy & (overrun_q | (complete & cmd_rdy_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= WAIT_HI;
            hi_q      <= '0;
            cmd_q     <= '0;
            cmd_rdy_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            cmd_q     <= cmd_d;
            cmd_rdy_q <= cmd_rdy_d;
            overrun_q <= overrun_d;
        end
    end

    assign cmd     = cmd_q;
    assign cmd_rdy = cmd_rdy_q;
    assign overrun = overrun_q;

endmodule
